// File: rtl/tdc_stat_pkg.sv
// Shared definitions for the TDC statistics sweep controller.
// Holds the sweep FSM states, default sizing of the accumulator RAM,
// the pixel-ID and epoch-number widths, and the pipeline drain length.
package tdc_stat_pkg;

    localparam int NPIX      = 256;  // pixel entries in the accumulator RAM
    localparam int REC_W     = 64;   // width of one accumulator record
    localparam int PIX_W     = 8;    // pixel-ID width
    localparam int SEC_W     = 18;   // epoch-number / time_stamp width
    localparam int DROP_W    = 16;   // dropped-hit counter width
    localparam int DRAIN_CYC = 2;    // cycles to let in-flight RMWs retire

    typedef enum logic [2:0] {
        ACCUM = 3'd0,
        DRAIN = 3'd1,
        RD    = 3'd2,
        CAP   = 3'd3,
        SEND  = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/tdc_sec_tick.sv
// One-second epoch generator.
// Counts 0..CLK_PER_SEC-1 and wraps; o_tick is high for the single wrap
// cycle. o_time_stamp counts ticks since reset (wraps at 2^SEC_W).
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   o_tick         1-cycle pulse on the last cycle of each epoch
//   o_time_stamp   seconds since reset
module tdc_sec_tick
    import tdc_stat_pkg::*;
#(
    parameter int CLK_PER_SEC = 40000000
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             o_tick,
    output logic [SEC_W-1:0] o_time_stamp
);

    localparam int               CNT_W   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [SEC_W-1:0] r_time_stamp;
    logic             w_tick;

    assign w_tick       = (r_cnt == CNT_MAX);
    assign o_tick       = w_tick;
    assign o_time_stamp = r_time_stamp;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt        <= '0;
            r_time_stamp <= '0;
        end else if (w_tick) begin
            r_cnt        <= '0;
            r_time_stamp <= r_time_stamp + 1'b1;
        end else begin
            r_cnt        <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdc_stat_sweep_ctrl.sv
// Owner of the shared per-pixel TDC statistics RAM.
// During an epoch every hit becomes an accumulate command. At each second
// boundary the accumulate pipeline is drained and every pixel entry is read
// (and cleared by the datapath), streaming one record per pixel out under
// valid/ready. Hits arriving while the sweep owns the RAM are dropped and
// counted.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACCUM | RAM owned by hits; a tick starts a sweep
// DRAIN | wait DRAIN_CYC cycles for in-flight accumulates to retire
// RD    | issue sweep read of entry r_addr
// CAP   | capture read data and record metadata into the output register
// SEND  | present record; advance on handshake, end after the last pixel
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   hit_valid, hit_pixel      incoming hit (not stallable)
//   acc_en, acc_addr          accumulate command, 1 cycle after the hit
//   mem_rd_en, mem_addr       sweep read; mem_rd_data returns 1 cycle later
//   out_valid/out_ready       record handshake toward the readout FIFO
//   out_data/pixel/sec/last   record payload and metadata
//   time_stamp                seconds since reset
//   drop_cnt                  saturating count of dropped hits
//   overrun                   sticky: tick seen while a sweep was running
module tdc_stat_sweep_ctrl
    import tdc_stat_pkg::*;
#(
    parameter int CLK_PER_SEC = 40000000,
    parameter int NPIX        = tdc_stat_pkg::NPIX,
    parameter int REC_W       = tdc_stat_pkg::REC_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hit_valid,
    input  logic [PIX_W-1:0]  hit_pixel,
    output logic              acc_en,
    output logic [PIX_W-1:0]  acc_addr,
    output logic              mem_rd_en,
    output logic [PIX_W-1:0]  mem_addr,
    input  logic [REC_W-1:0]  mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REC_W-1:0]  out_data,
    output logic [PIX_W-1:0]  out_pixel,
    output logic [SEC_W-1:0]  out_sec,
    output logic              out_last,
    output logic [SEC_W-1:0]  time_stamp,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overrun
);

    localparam int                DRN_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0]  DRAIN_LOAD = DRN_W'(DRAIN_CYC - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(NPIX - 1);
    localparam logic [DROP_W-1:0] DROP_MAX   = '1;

    sweep_state_t      r_state;
    sweep_state_t      w_next;
    logic              w_tick;
    logic [SEC_W-1:0]  w_time_stamp;

    logic [DRN_W-1:0]  r_drain_cnt;
    logic [PIX_W-1:0]  r_addr;
    logic [SEC_W-1:0]  r_sweep_sec;
    logic              r_acc_en;
    logic [PIX_W-1:0]  r_acc_addr;
    logic [REC_W-1:0]  r_out_data;
    logic [PIX_W-1:0]  r_out_pixel;
    logic [SEC_W-1:0]  r_out_sec;
    logic              r_out_last;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overrun;

    tdc_sec_tick #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_sec_tick (
        .clk          (clk),
        .rstn         (rstn),
        .o_tick       (w_tick),
        .o_time_stamp (w_time_stamp)
    );

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ACCUM;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_tick) w_next = DRAIN;
            DRAIN:   if (r_drain_cnt == '0) w_next = RD;
            RD:      w_next = CAP;
            CAP:     w_next = SEND;
            SEND:    if (out_ready) w_next = r_out_last ? ACCUM : RD;
            default: w_next = ACCUM;
        endcase
    end

    always_comb begin
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            RD:      mem_rd_en = 1'b1;
            SEND:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_drain_cnt <= '0;
            r_addr      <= '0;
            r_sweep_sec <= '0;
            r_acc_en    <= 1'b0;
            r_acc_addr  <= '0;
            r_out_data  <= '0;
            r_out_pixel <= '0;
            r_out_sec   <= '0;
            r_out_last  <= 1'b0;
            r_drop_cnt  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            // A hit on the tick cycle still sees ACCUM, so it lands in the
            // epoch that is ending; the drain covers its RMW.
            r_acc_en <= hit_valid && (r_state == ACCUM);
            if (hit_valid && (r_state == ACCUM))
                r_acc_addr <= hit_pixel;

            if (hit_valid && (r_state != ACCUM) && (r_drop_cnt != DROP_MAX))
                r_drop_cnt <= r_drop_cnt + 1'b1;

            if (w_tick && (r_state != ACCUM))
                r_overrun <= 1'b1;

            case (r_state)
                ACCUM: begin
                    if (w_tick) begin
                        // time_stamp still holds the ending epoch's number here
                        r_sweep_sec <= w_time_stamp;
                        r_drain_cnt <= DRAIN_LOAD;
                        r_addr      <= '0;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt != '0)
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                end
                CAP: begin
                    r_out_data  <= mem_rd_data;
                    r_out_pixel <= r_addr;
                    r_out_sec   <= r_sweep_sec;
                    r_out_last  <= (r_addr == LAST_PIX);
                end
                SEND: begin
                    if (out_ready && !r_out_last)
                        r_addr <= r_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign acc_en     = r_acc_en;
    assign acc_addr   = r_acc_addr;
    assign mem_addr   = r_addr;
    assign out_data   = r_out_data;
    assign out_pixel  = r_out_pixel;
    assign out_sec    = r_out_sec;
    assign out_last   = r_out_last;
    assign time_stamp = w_time_stamp;
    assign drop_cnt   = r_drop_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_tdc_stat_sweep_ctrl.sv
// Randomized bench for tdc_stat_sweep_ctrl with an event-level reference
// model (per-epoch hit histograms, sweep as a timed record sequence) and an
// emulated accumulator RAM answering acc_en / mem_rd_en.
module tb_tdc_stat_sweep_ctrl;

    localparam int CPS = 1000;
    localparam int NP  = 256;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hit_valid;
    logic [7:0]  hit_pixel;
    logic        acc_en;
    logic [7:0]  acc_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [63:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_pixel;
    logic [17:0] out_sec;
    logic        out_last;
    logic [17:0] time_stamp;
    logic [15:0] drop_cnt;
    logic        overrun;

    always #5 clk = ~clk;

    tdc_stat_sweep_ctrl #(
        .CLK_PER_SEC (CPS),
        .NPIX        (NP),
        .REC_W       (64)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .hit_valid   (hit_valid),
        .hit_pixel   (hit_pixel),
        .acc_en      (acc_en),
        .acc_addr    (acc_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pixel   (out_pixel),
        .out_sec     (out_sec),
        .out_last    (out_last),
        .time_stamp  (time_stamp),
        .drop_cnt    (drop_cnt),
        .overrun     (overrun)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int c      = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, c);
    endtask

    // environment RAM
    logic [63:0] ram [NP];
    logic [63:0] rd_q;
    bit          rd_pend;

    // reference model
    int  hist [NP];
    int  snap [NP];
    bit  busy;
    int  pix, valid_at, sweep_sec, ts, drop;
    bit  ovr;
    bit  exp_acc;
    int  exp_acc_addr;
    int  hs_cnt, last_cnt, last_hs, tick_cyc;

    task automatic model_reset();
        busy = 0; pix = 0; valid_at = 0; sweep_sec = 0;
        ts = 0; drop = 0; ovr = 0; exp_acc = 0; exp_acc_addr = 0;
        rd_pend = 0;
        for (int k = 0; k < NP; k++) hist[k] = 0;
    endtask

    task automatic step(input bit rst, input bit hv, input int hp, input bit rdy);
        bit was_busy;
        bit in_send;
        bit rd_now;
        @(posedge clk);
        #1;
        rstn        = ~rst;
        hit_valid   = hv;
        hit_pixel   = 8'(hp);
        out_ready   = rdy;
        mem_rd_data = rd_pend ? rd_q : {$urandom, $urandom};
        rd_pend     = 0;
        @(negedge clk);

        in_send = busy && (c >= valid_at);
        rd_now  = busy && (c == valid_at - 2);
        chk("acc_en", 64'(acc_en), 64'(exp_acc));
        if (exp_acc) chk("acc_addr", 64'(acc_addr), 64'(exp_acc_addr));
        chk("rd_acc_excl", 64'(acc_en && mem_rd_en), 64'(0));
        chk("mem_rd_en", 64'(mem_rd_en), 64'(rd_now));
        if (rd_now) chk("mem_addr", 64'(mem_addr), 64'(pix));
        chk("out_valid", 64'(out_valid), 64'(in_send));
        if (in_send) begin
            chk("out_pixel", 64'(out_pixel), 64'(pix));
            chk("out_data", out_data, 64'(snap[pix]));
            chk("out_sec", 64'(out_sec), 64'(sweep_sec));
            chk("out_last", 64'(out_last), 64'(pix == NP - 1));
        end
        chk("time_stamp", 64'(time_stamp), 64'(ts));
        chk("drop_cnt", 64'(drop_cnt), 64'(drop));
        chk("overrun", 64'(overrun), 64'(ovr));

        if (acc_en) ram[acc_addr] = ram[acc_addr] + 64'd1;
        if (mem_rd_en) begin
            rd_q = ram[mem_addr];
            ram[mem_addr] = '0;
            rd_pend = 1;
        end
        if (out_valid && out_ready) begin
            hs_cnt++;
            if (out_last) begin
                last_cnt++;
                last_hs = c;
            end
        end

        if (rst) begin
            model_reset();
            c = 0;
            return;
        end

        was_busy     = busy;
        exp_acc      = hv && !was_busy;
        exp_acc_addr = hp;
        if (hv && !was_busy) hist[hp]++;
        if (hv && was_busy && drop != 65535) drop++;
        if (was_busy && c >= valid_at && rdy) begin
            if (pix == NP - 1) busy = 0;
            else begin
                pix++;
                valid_at = c + 3;
            end
        end
        if (c % CPS == CPS - 1) begin
            if (was_busy) ovr = 1;
            else begin
                busy      = 1;
                pix       = 0;
                valid_at  = c + 5;
                sweep_sec = ts;
                tick_cyc  = c;
                hs_cnt    = 0;
                last_cnt  = 0;
                for (int k = 0; k < NP; k++) begin
                    snap[k] = hist[k];
                    hist[k] = 0;
                end
            end
            ts = (ts + 1) & 32'h3FFFF;
        end
        c++;
    endtask

    initial begin
        bit post;
        rstn = 1'b0; hit_valid = 1'b0; hit_pixel = '0; out_ready = 1'b0; mem_rd_data = '0;
        for (int k = 0; k < NP; k++) begin
            ram[k]  = '0;
            snap[k] = 0;
        end
        model_reset();
        hs_cnt = 0; last_cnt = 0; last_hs = 0; tick_cyc = 0;
        post = 0;
        repeat (3) @(posedge clk);

        for (int g = 0; g < 8000; g++) begin
            bit hv, rdy, rs;
            int hp;
            hp  = int'($urandom_range(0, NP - 1));
            hv  = ($urandom_range(0, 3) == 0);
            rdy = 1; rs = 0;

            if (post) begin
                if (c == 1) begin
                    chk("rst_out_valid", 64'(out_valid), 64'(0));
                    chk("rst_time_stamp", 64'(time_stamp), 64'(0));
                    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
                end
                if (c >= 60) begin
                    chk("abandon_no_last", 64'(last_cnt), 64'(0));
                    break;
                end
            end else begin
                if (c == 1800) begin
                    chk("sweep0_len", 64'(last_hs - tick_cyc), 64'(770));
                    chk("sweep0_recs", 64'(hs_cnt), 64'(256));
                    chk("sweep0_last", 64'(last_cnt), 64'(1));
                end
                if (c == 2800) chk("drop_770", 64'(drop_cnt), 64'(770));
                if (c == 3990) chk("ovr_clear", 64'(overrun), 64'(0));
                if (c == 4010) begin
                    chk("ovr_set", 64'(overrun), 64'(1));
                    chk("ts_at_stall", 64'(time_stamp), 64'(4));
                    chk("stall_valid", 64'(out_valid), 64'(1));
                    chk("stall_pixel", 64'(out_pixel), 64'(1));
                end
                if (c == 4990 || c == 6990) begin
                    chk("sweep_recs", 64'(hs_cnt), 64'(256));
                    chk("sweep_last", 64'(last_cnt), 64'(1));
                end

                if (c >= 100 && c <= 104) begin
                    hv = 1; hp = 7;
                end else if (c >= 990 && c < 1990) begin
                    hv = 0;
                end else if (c >= 1990 && c < 2780) begin
                    hv = 1;
                end else if (c >= 2999 && c < 4999) begin
                    rdy = (c <= 3004) || (c >= 4100);
                end else if (c >= 4999 && c < 6999) begin
                    rdy = ($urandom_range(0, 99) < 30);
                end else if (c >= 6999 && busy && pix == 40 && c == valid_at) begin
                    rs = 1; rdy = 0; hv = 0; post = 1;
                end
            end
            step(rs, hv, hp, rdy);
        end

        chk("run_completed", 64'(post && c >= 60), 64'(1));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
